// File: rtl/pic_prog_mem.sv
// Loadable program memory: registered one-cycle instruction fetch plus a valid/ready boot-load port.
// Optional per-word parity is enabled by defining PIC_PROG_MEM_PARITY_EN.
module pic_prog_mem #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    input  logic              boot_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              ld_par_flip,
    output logic              ld_ready,
    output logic              boot_busy,
    output logic              load_done,
    output logic [ADDR_W:0]   ld_count,
    output logic              parity_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PIC_PROG_MEM_PARITY_EN
    localparam int MW = DATA_W + 1;
`else
    localparam int MW = DATA_W;
`endif

    // Handshake: a load word transfers on a rising edge where ld_valid && ld_ready.
    typedef enum logic {IDLE, LOAD} state_t;
    state_t state;

    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;
    logic          in_range;
    logic          accept;
    logic          last_word;

    assign rd_idx    = addr[IW-1:0];
    assign wr_idx    = ld_count[IW-1:0];
    assign in_range  = {1'b0, addr} < (ADDR_W+1)'(DEPTH);
    assign accept    = (state == LOAD) && ld_valid && ld_ready;
    assign last_word = ld_last || (ld_count == (ADDR_W+1)'(DEPTH - 1));
    assign rd_word   = mem[rd_idx];
    assign boot_busy = (state == LOAD);

`ifdef PIC_PROG_MEM_PARITY_EN
    assign wr_word = {(^ld_data) ^ ld_par_flip, ld_data};
`else
    logic unused_par;
    assign wr_word    = ld_data;
    assign unused_par = ld_par_flip;
    assign parity_err = 1'b0;
`endif

    // Contents deliberately survive reset; a reset cycle never writes.
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            mem[wr_idx] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            data       <= '0;
            data_valid <= 1'b0;
            ld_ready   <= 1'b0;
            load_done  <= 1'b0;
            ld_count   <= '0;
`ifdef PIC_PROG_MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            load_done  <= 1'b0;
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (boot_start) begin
                        state    <= LOAD;
                        ld_ready <= 1'b1;
                        ld_count <= '0;
                    end else if (fetch_en) begin
                        data_valid <= 1'b1;
                        data       <= in_range ? rd_word[DATA_W-1:0] : '0;
`ifdef PIC_PROG_MEM_PARITY_EN
                        // Stored bit included, so odd overall parity means mismatch.
                        parity_err <= in_range && (^rd_word);
`endif
                    end
                end
                LOAD: begin
                    if (accept) begin
                        ld_count <= ld_count + 1'b1;
                        if (last_word) begin
                            state     <= IDLE;
                            ld_ready  <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pic_prog_mem.sv
// Directed bench for pic_prog_mem: default 512-word instance plus a 4-word instance for the depth cap.
module tb_pic_prog_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en, boot_start, ld_valid, ld_last, ld_par_flip;
    logic [8:0]  addr;
    logic [11:0] ld_data, data;
    logic        data_valid, ld_ready, boot_busy, load_done, parity_err;
    logic [9:0]  ld_count;

    logic        s_fetch_en, s_boot_start, s_ld_valid, s_ld_last;
    logic [8:0]  s_addr;
    logic [11:0] s_ld_data, s_data;
    logic        s_data_valid, s_ld_ready, s_boot_busy, s_load_done, s_parity_err;
    logic [9:0]  s_ld_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [8:0]  a;
        logic [11:0] d;
        logic        perr;
    } fvec_t;

    fvec_t tbl[6];
    logic [11:0] wq[$];
    logic exp_flip_perr;

    always #5 clk = ~clk;

    pic_prog_mem dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .addr(addr), .data(data),
        .data_valid(data_valid), .boot_start(boot_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_par_flip(ld_par_flip),
        .ld_ready(ld_ready), .boot_busy(boot_busy), .load_done(load_done),
        .ld_count(ld_count), .parity_err(parity_err)
    );

    pic_prog_mem #(.ADDR_W(9), .DATA_W(12), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .fetch_en(s_fetch_en), .addr(s_addr), .data(s_data),
        .data_valid(s_data_valid), .boot_start(s_boot_start), .ld_valid(s_ld_valid),
        .ld_data(s_ld_data), .ld_last(s_ld_last), .ld_par_flip(1'b0),
        .ld_ready(s_ld_ready), .boot_busy(s_boot_busy), .load_done(s_load_done),
        .ld_count(s_ld_count), .parity_err(s_parity_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fetch_chk(input string name, input logic [8:0] a, input logic [11:0] d,
                             input logic perr);
        fetch_en = 1'b1;
        addr     = a;
        step();
        chk({name, "_data"}, data, d);
        chk({name, "_valid"}, data_valid, 1'b1);
        chk({name, "_perr"}, parity_err, perr);
    endtask

    // Loads wq[0..n-1] from address 0; fetch_en may be held high to prove it is ignored.
    task automatic do_load(input int n, input logic gaps, input logic fe_hold, input logic flip);
        int pulses = 0;
        fetch_en   = fe_hold;
        boot_start = 1'b1;
        step();
        boot_start = 1'b0;
        chk("load_busy", boot_busy, 1'b1);
        chk("load_ready_rise", ld_ready, 1'b1);
        chk("load_start_nodv", data_valid, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                ld_valid = 1'b0;
                step();
                chk("load_gap_nodv", data_valid, 1'b0);
                pulses += int'(load_done);
            end
            ld_valid    = 1'b1;
            ld_data     = wq[i];
            ld_last     = (i == n - 1);
            ld_par_flip = flip;
            chk("load_ready", ld_ready, 1'b1);
            step();
            chk("load_nodv", data_valid, 1'b0);
            pulses += int'(load_done);
        end
        ld_valid    = 1'b0;
        ld_last     = 1'b0;
        ld_par_flip = 1'b0;
        fetch_en    = 1'b0;
        chk("load_count", ld_count, 32'(n));
        chk("load_ready_fall", ld_ready, 1'b0);
        chk("load_busy_fall", boot_busy, 1'b0);
        step();
        pulses += int'(load_done);
        chk("load_done_pulses", pulses, 1);
    endtask

    initial begin
`ifdef PIC_PROG_MEM_PARITY_EN
        exp_flip_perr = 1'b1;
`else
        exp_flip_perr = 1'b0;
`endif
        tbl[0] = '{9'd0, 12'hC09, 1'b0};
        tbl[1] = '{9'd1, 12'h028, 1'b0};
        tbl[2] = '{9'd2, 12'hC08, 1'b0};
        tbl[3] = '{9'd3, 12'h000, 1'b0};
        tbl[4] = '{9'd1, 12'h028, 1'b0};
        tbl[5] = '{9'd511, 12'h000, 1'b0};

        reset = 1'b1; fetch_en = 1'b0; addr = '0; boot_start = 1'b0; ld_valid = 1'b0;
        ld_data = '0; ld_last = 1'b0; ld_par_flip = 1'b0;
        s_fetch_en = 1'b0; s_addr = '0; s_boot_start = 1'b0; s_ld_valid = 1'b0;
        s_ld_data = '0; s_ld_last = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_data", data, 12'h000);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_ready", ld_ready, 1'b0);
        chk("rst_busy", boot_busy, 1'b0);
        chk("rst_done", load_done, 1'b0);
        chk("rst_count", ld_count, 10'd0);
        chk("rst_perr", parity_err, 1'b0);

        fetch_chk("fetch_unloaded", 9'd0, 12'h000, 1'b0);
        fetch_en = 1'b0;
        step();
        chk("idle_nodv", data_valid, 1'b0);

        wq = '{12'hC09, 12'h028, 12'hC08};
        do_load(3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) fetch_chk($sformatf("tbl%0d", i), tbl[i].a, tbl[i].d, tbl[i].perr);
        fetch_en = 1'b0;
        step();
        chk("hold_nodv", data_valid, 1'b0);
        chk("hold_data", data, 12'h000);

        // Gapped load with fetch_en high throughout, boot_start colliding with fetch_en.
        wq = '{12'hC09, 12'h028, 12'hC08};
        do_load(3, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) fetch_chk($sformatf("gap_tbl%0d", i), tbl[i].a, tbl[i].d, tbl[i].perr);
        fetch_en = 1'b0;

        // Reset after two of five words.
        boot_start = 1'b1;
        step();
        boot_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = 12'h5A0 + 12'(i);
            step();
        end
        ld_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_count", ld_count, 10'd0);
        chk("midrst_busy", boot_busy, 1'b0);
        chk("midrst_ready", ld_ready, 1'b0);
        fetch_chk("midrst_a0", 9'd0, 12'h5A0, 1'b0);
        fetch_chk("midrst_a1", 9'd1, 12'h5A1, 1'b0);
        fetch_chk("midrst_a2", 9'd2, 12'hC08, 1'b0);
        fetch_en = 1'b0;

        wq = '{12'h0A5};
        do_load(1, 1'b0, 1'b0, 1'b1);
        fetch_chk("par_flip", 9'd0, 12'h0A5, exp_flip_perr);
        fetch_chk("par_neighbour", 9'd1, 12'h5A1, 1'b0);
        fetch_en = 1'b0;
        do_load(1, 1'b0, 1'b0, 1'b0);
        fetch_chk("par_clean", 9'd0, 12'h0A5, 1'b0);
        fetch_en = 1'b0;

        // Four-word instance: six words offered, no ld_last.
        s_boot_start = 1'b1;
        step();
        s_boot_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_ld_valid = 1'b1;
            s_ld_data  = 12'h100 + 12'(i);
            chk($sformatf("d4_ready%0d", i), s_ld_ready, (i < 4) ? 1'b1 : 1'b0);
            step();
            chk($sformatf("d4_done%0d", i), s_load_done, (i == 3) ? 1'b1 : 1'b0);
        end
        s_ld_valid = 1'b0;
        chk("d4_count", s_ld_count, 10'd4);
        chk("d4_busy", s_boot_busy, 1'b0);
        s_fetch_en = 1'b1;
        s_addr = 9'd3;
        step();
        chk("d4_a3", s_data, 12'h103);
        s_addr = 9'd5;
        step();
        chk("d4_a5", s_data, 12'h000);
        chk("d4_a5_valid", s_data_valid, 1'b1);
        chk("d4_a5_perr", s_parity_err, 1'b0);
        s_addr = 9'd0;
        step();
        chk("d4_a0", s_data, 12'h100);
        s_fetch_en = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pic_prog_mem.md
# pic_prog_mem

Parametrised, loadable program memory for the structural PIC core; successor to the fixed 512×12 combinational program ROM. Holds DEPTH instruction words of DATA_W bits. Serves instruction fetches with a registered one-cycle read. Can be (re)filled at run time through a valid/ready boot-load stream while the core is held off. Sits between the program counter/fetch stage and an external boot loader (UART/JTAG bridge or testbench).

## Interface
- ADDR_W, 9, fetch/load address width.
- DATA_W, 12, instruction word width.
- DEPTH, 512, number of implemented words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- fetch_en  in  1  fetch request for `addr`.
- addr  in  ADDR_W  fetch address.
- data  out  DATA_W  registered instruction word.
- data_valid  out  1  `data` holds the result of the fetch issued the previous cycle.
- boot_start  in  1  single-cycle pulse that begins a load session.
- ld_valid  in  1  load word offered.
- ld_data  in  DATA_W  load word.
- ld_last  in  1  marks the final word of the session, qualified by ld_valid.
- ld_par_flip  in  1  test hook: store inverted parity for this word; ignored without the parity macro.
- ld_ready  out  1  block accepts a load word this cycle.
- boot_busy  out  1  high during LOAD; core must stall fetch.
- load_done  out  1  one-cycle pulse when a session ends.
- ld_count  out  ADDR_W+1  number of words written in the current or last session.
- parity_err  out  1  parity mismatch on the word in `data`; qualified by data_valid.

## Operation
- FSM has two states, IDLE and LOAD. Reset enters IDLE.
- IDLE:
  - fetch_en=1 reads mem[addr] into `data`.
  - If addr ≥ DEPTH, `data` loads 0.
  - boot_start=1 moves to LOAD and clears the write pointer and ld_count to 0.
- LOAD:
  - ld_ready=1 and boot_busy=1.
  - Each cycle with ld_valid && ld_ready writes ld_data to mem[ptr], then increments ptr and ld_count.
  - The session ends on an accepted word with ld_last=1, or on acceptance of word DEPTH-1. Ending returns the FSM to IDLE and pulses load_done in the following cycle.
  - Words offered after the session ends see ld_ready=0 and are not written.
- In LOAD, fetch_en is ignored, data_valid=0, and `data` holds its value. boot_start is ignored.
- boot_start and fetch_en in the same IDLE cycle: boot_start wins; no fetch is performed.
- Memory contents are not cleared by reset and are retained across sessions. Unwritten words keep their prior values; simulation initial value is 0.
- Reset mid-LOAD: return to IDLE, ptr=0, ld_count=0. Words already written remain.

## Timing
- Fetch latency is 1 cycle: fetch_en at edge N gives data/data_valid/parity_err valid after edge N+1. Back-to-back fetches sustain one word per cycle.
- data_valid is high for exactly the cycles following a performed fetch.
- `data` holds its last value when no fetch is performed.
- ld_ready is registered: it rises the cycle after boot_start and falls the cycle after the final accepted word.
- boot_busy equals (state==LOAD).
- A fetch issued in the first IDLE cycle after a load returns the newly written contents; there is no read-during-write hazard because fetch is blocked in LOAD.
- Reset values: data=0, data_valid=0, ld_ready=0, boot_busy=0, load_done=0, ld_count=0, parity_err=0.

## Configuration
- PIC_PROG_MEM_PARITY_EN defined:
  - Each stored word carries one extra bit equal to ^ld_data, XOR ld_par_flip.
  - On fetch, parity_err is registered as the recomputed parity ≠ the stored bit. It has the same timing as `data`.
  - Out-of-range reads give parity_err=0.
- PIC_PROG_MEM_PARITY_EN undefined:
  - No parity storage.
  - parity_err is tied to 0 and ld_par_flip is ignored.
  - Port list is unchanged.

## Test plan
- Reset, then fetch addr=0 with no prior load → after 1 cycle, data=0x000, data_valid=1. All other outputs are at their reset values.
- boot_start, then 3 words 0xC09, 0x028, 0xC08 with ld_last on the third → ld_count=3 and load_done pulses once. Fetching addrs 0,1,2 back-to-back returns 0xC09, 0x028, 0xC08 on consecutive cycles.
- Gaps in ld_valid during a load, and fetch_en held high throughout LOAD → no data_valid in LOAD. The load result is identical to the gap-free case.
- DEPTH=4 with 6 words offered and no ld_last → only 4 are written, ld_ready drops after the 4th, ld_count=4. Fetching addr=5 returns 0.
- Reset asserted after 2 of 5 words → IDLE, ld_count=0. addr 0–1 hold the new words; addr 2 holds its old value.
- With PIC_PROG_MEM_PARITY_EN: load 0x0A5 with ld_par_flip=1, then fetch → data=0x0A5, parity_err=1. A word loaded with ld_par_flip=0 fetches with parity_err=0. Without the macro, parity_err stays 0 in both cases.
